// File: rtl/hyperbus_rx_packer.sv
// +--------------------------------------------------------------------------+
// | hyperbus_rx_packer                                                       |
// | Packs 16-bit RX words into DataWidth-bit beats with keep/last/error.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module hyperbus_rx_packer #(
  parameter int DataWidth     = 32,
  parameter int LenWidth      = 16,
  parameter int TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [LenWidth-1:0]    cmd_len_i,
  input  logic [(((DataWidth/16) > 1) ? $clog2(DataWidth/16) : 1)-1:0] cmd_offs_i,
  input  logic [15:0]            rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  output logic [DataWidth-1:0]   out_data_o,
  output logic [DataWidth/8-1:0] out_keep_o,
  output logic                   out_last_o,
  output logic                   out_error_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   busy_o,
  output logic                   stray_o
);

  localparam int c_NW = DataWidth / 16;
  localparam int c_OW = (c_NW > 1) ? $clog2(c_NW) : 1;
  localparam int c_TW = $clog2(TimeoutCycles + 1);
  localparam logic [c_OW-1:0] c_LAST_LANE  = c_OW'(c_NW - 1);
  localparam logic [c_TW-1:0] c_TIMEOUT    = c_TW'(TimeoutCycles);
  localparam logic [c_TW-1:0] c_TIMEOUT_M1 = c_TW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ABORT   = 2'd2
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [c_OW-1:0]        r_lane;
  logic [LenWidth-1:0]    r_remaining;
  logic [c_TW-1:0]        r_timer;
  logic [DataWidth-1:0]   r_asm_data;
  logic [DataWidth/8-1:0] r_asm_keep;
  logic [DataWidth-1:0]   r_out_data;
  logic [DataWidth/8-1:0] r_out_keep;
  logic                   r_out_last;
  logic                   r_out_error;
  logic                   r_out_valid;
  logic                   r_stray;

  logic [DataWidth-1:0]   w_asm_data;
  logic [DataWidth/8-1:0] w_asm_keep;
  logic                   w_complete;
  logic                   w_rem_zero;
  logic                   w_cmd_fire;
  logic                   w_collect_fire;
  logic                   w_stray;
  logic                   w_abort_load;
  logic                   w_cmd_ready;
  logic                   w_rx_ready;

  // Assembly register view with the incoming word merged into the current lane
  for (genvar i = 0; i < c_NW; i++) begin : g_lane
    localparam logic [c_OW-1:0] c_IDX = c_OW'(i);
    assign w_asm_data[16*i +: 16] = (r_lane == c_IDX) ? rx_data_i : r_asm_data[16*i +: 16];
    assign w_asm_keep[2*i +: 2]   = (r_lane == c_IDX) ? 2'b11     : r_asm_keep[2*i +: 2];
  end

  assign w_rem_zero = (r_remaining == '0);
  assign w_complete = (r_lane == c_LAST_LANE) || w_rem_zero;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cmd_ready    = 1'b0;
    w_rx_ready     = 1'b0;
    w_cmd_fire     = 1'b0;
    w_collect_fire = 1'b0;
    w_stray        = 1'b0;
    w_abort_load   = 1'b0;
    case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        w_rx_ready  = 1'b1;
        w_stray     = rx_valid_i;
        w_cmd_fire  = cmd_valid_i;
        if (cmd_valid_i) begin
          w_state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        // Stall only when this word would complete a beat that has nowhere to go
        w_rx_ready     = !w_complete || !r_out_valid || out_ready_i;
        w_collect_fire = rx_valid_i && w_rx_ready;
        if (w_collect_fire && w_rem_zero) begin
          w_state_nxt = IDLE;
        end else if (!rx_valid_i && (r_timer == c_TIMEOUT_M1)) begin
          w_state_nxt = ABORT;
        end
      end
      ABORT: begin
        if (!r_out_valid || out_ready_i) begin
          w_abort_load = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lane      <= '0;
      r_remaining <= '0;
      r_timer     <= '0;
      r_asm_data  <= '0;
      r_asm_keep  <= '0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_out_error <= 1'b0;
      r_out_valid <= 1'b0;
      r_stray     <= 1'b0;
    end else begin
      r_stray <= w_stray;
      if (r_out_valid && out_ready_i) begin
        r_out_valid <= 1'b0;
      end
      if (w_cmd_fire) begin
        r_remaining <= cmd_len_i;
        r_lane      <= (c_NW == 1) ? '0 : cmd_offs_i;
        r_asm_keep  <= '0;
        r_timer     <= '0;
      end
      if (w_collect_fire) begin
        r_timer    <= '0;
        r_asm_data <= w_asm_data;
        if (!w_rem_zero) begin
          r_remaining <= r_remaining - LenWidth'(1);
        end
        if (w_complete) begin
          r_out_data  <= w_asm_data;
          r_out_keep  <= w_asm_keep;
          r_out_last  <= w_rem_zero;
          r_out_error <= 1'b0;
          r_out_valid <= 1'b1;
          r_lane      <= '0;
          r_asm_keep  <= '0;
        end else begin
          r_lane     <= r_lane + c_OW'(1);
          r_asm_keep <= w_asm_keep;
        end
      end else if ((r_state == COLLECT) && !rx_valid_i && (r_timer != c_TIMEOUT)) begin
        r_timer <= r_timer + c_TW'(1);
      end
      if (w_abort_load) begin
        r_out_data  <= r_asm_data;
        r_out_keep  <= r_asm_keep;
        r_out_last  <= 1'b1;
        r_out_error <= 1'b1;
        r_out_valid <= 1'b1;
        r_asm_keep  <= '0;
      end
    end
  end

  assign cmd_ready_o = w_cmd_ready;
  assign rx_ready_o  = w_rx_ready;
  assign out_data_o  = r_out_data;
  assign out_keep_o  = r_out_keep;
  assign out_last_o  = r_out_last;
  assign out_error_o = r_out_error;
  assign out_valid_o = r_out_valid;
  assign busy_o      = (r_state != IDLE);
  assign stray_o     = r_stray;

endmodule

`default_nettype wire

// File: tb/tb_hyperbus_rx_packer.sv
// +--------------------------------------------------------------------------+
// | tb_hyperbus_rx_packer                                                    |
// | Directed scoreboard bench for hyperbus_rx_packer (DataWidth=32).         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_hyperbus_rx_packer;

  localparam int c_DW = 32;
  localparam int c_LW = 16;
  localparam int c_TO = 16;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            cmd_valid_i;
  logic            cmd_ready_o;
  logic [c_LW-1:0] cmd_len_i;
  logic [0:0]      cmd_offs_i;
  logic [15:0]     rx_data_i;
  logic            rx_valid_i;
  logic            rx_ready_o;
  logic [c_DW-1:0] out_data_o;
  logic [3:0]      out_keep_o;
  logic            out_last_o;
  logic            out_error_o;
  logic            out_valid_o;
  logic            out_ready_i;
  logic            busy_o;
  logic            stray_o;

  hyperbus_rx_packer #(
    .DataWidth    (c_DW),
    .LenWidth     (c_LW),
    .TimeoutCycles(c_TO)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_len_i  (cmd_len_i),
    .cmd_offs_i (cmd_offs_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .out_data_o (out_data_o),
    .out_keep_o (out_keep_o),
    .out_last_o (out_last_o),
    .out_error_o(out_error_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .busy_o     (busy_o),
    .stray_o    (stray_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        err;
  } beat_t;

  beat_t sb[$];
  int    vectors = 0;
  int    errors  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] keep_mask(input logic [3:0] k);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = k[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k,
                               input logic l, input logic e);
    beat_t b;
    b.data = d & keep_mask(k);
    b.keep = k;
    b.last = l;
    b.err  = e;
    return b;
  endfunction

  // Output monitor: every accepted beat is checked against the scoreboard head
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", {32'h0, out_data_o}, 64'hDEAD);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("beat_data", {32'h0, out_data_o & keep_mask(out_keep_o)}, {32'h0, e.data});
        chk("beat_keep", {60'h0, out_keep_o}, {60'h0, e.keep});
        chk("beat_last", {63'h0, out_last_o}, {63'h0, e.last});
        chk("beat_error", {63'h0, out_error_o}, {63'h0, e.err});
      end
    end
  end

  // All stimulus tasks start and end at posedge+1
  task automatic send_cmd(input logic [c_LW-1:0] len, input logic offs);
    int n;
    cmd_valid_i = 1'b1;
    cmd_len_i   = len;
    cmd_offs_i  = offs;
    n = 0;
    @(negedge clk_i);
    while (!cmd_ready_o && n < 50) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) chk("cmd_timeout", 64'(n), 64'h0);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d, output int stalls);
    rx_valid_i = 1'b1;
    rx_data_i  = d;
    stalls = 0;
    @(negedge clk_i);
    while (!rx_ready_o && stalls < 50) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      stalls++;
    end
    if (stalls >= 50) chk("word_timeout", 64'(stalls), 64'h0);
    @(posedge clk_i); #1;
  endtask

  task automatic idle_rx();
    rx_valid_i = 1'b0;
  endtask

  task automatic drain_sb(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk(tag, 64'(sb.size()), 64'h0);
  endtask

  task automatic scenario1(input string tag);
    int st;
    sb.push_back(mk(32'h2222_1111, 4'hF, 1'b0, 1'b0));
    sb.push_back(mk(32'h4444_3333, 4'hF, 1'b1, 1'b0));
    send_cmd(16'd3, 1'b0);
    send_word(16'h1111, st);
    chk({tag, "_stall1"}, 64'(st), 64'h0);
    send_word(16'h2222, st);
    chk({tag, "_valid_after_beat1"}, {63'h0, out_valid_o}, 64'h1);
    send_word(16'h3333, st);
    chk({tag, "_stall3"}, 64'(st), 64'h0);
    send_word(16'h4444, st);
    idle_rx();
    chk({tag, "_cmd_ready_after_last"}, {63'h0, cmd_ready_o}, 64'h1);
    chk({tag, "_valid_after_beat2"}, {63'h0, out_valid_o}, 64'h1);
    drain_sb({tag, "_drain"});
  endtask

  initial begin
    int st;
    int cnt;
    int pulses;
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_len_i   = '0;
    cmd_offs_i  = '0;
    rx_data_i   = '0;
    rx_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_cmd_ready", {63'h0, cmd_ready_o}, 64'h1);
    chk("rst_rx_ready", {63'h0, rx_ready_o}, 64'h1);
    chk("rst_out_valid", {63'h0, out_valid_o}, 64'h0);
    chk("rst_busy", {63'h0, busy_o}, 64'h0);
    chk("rst_out_data", {32'h0, out_data_o}, 64'h0);
    chk("rst_out_flags", {58'h0, out_keep_o, out_last_o, out_error_o}, 64'h0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Aligned burst, two full beats
    scenario1("s1");

    // Offset start: first beat only upper lane, second only lower lane
    sb.push_back(mk(32'hAAAA_0000, 4'hC, 1'b0, 1'b0));
    sb.push_back(mk(32'h0000_BBBB, 4'h3, 1'b1, 1'b0));
    send_cmd(16'd1, 1'b1);
    send_word(16'hAAAA, st);
    send_word(16'hBBBB, st);
    idle_rx();
    drain_sb("s2_drain");

    // Backpressure: beat1 held, completing word must stall
    out_ready_i = 1'b0;
    sb.push_back(mk(32'h2222_1111, 4'hF, 1'b0, 1'b0));
    sb.push_back(mk(32'h4444_3333, 4'hF, 1'b1, 1'b0));
    send_cmd(16'd3, 1'b0);
    send_word(16'h1111, st);
    send_word(16'h2222, st);
    send_word(16'h3333, st);
    chk("s3_lane0_accepted", 64'(st), 64'h0);
    rx_valid_i = 1'b1;
    rx_data_i  = 16'h4444;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("s3_rx_ready_stalled", {63'h0, rx_ready_o}, 64'h0);
      @(posedge clk_i); #1;
    end
    out_ready_i = 1'b1;
    send_word(16'h4444, st);
    idle_rx();
    drain_sb("s3_drain");

    // Timeout abort after one word
    sb.push_back(mk(32'h0000_5555, 4'h3, 1'b1, 1'b1));
    send_cmd(16'd3, 1'b0);
    send_word(16'h5555, st);
    idle_rx();
    cnt = 0;
    @(negedge clk_i);
    while (!out_valid_o && cnt < 40) begin
      cnt++;
      @(negedge clk_i);
    end
    chk("s4_abort_delay_in_range", {63'h0, (cnt >= c_TO && cnt <= c_TO + 2)}, 64'h1);
    @(posedge clk_i); #1;
    drain_sb("s4_drain");
    chk("s4_idle_after_abort", {63'h0, busy_o}, 64'h0);
    // Late word drained as stray, producing no beat
    rx_valid_i = 1'b1;
    rx_data_i  = 16'h6666;
    pulses = 0;
    @(negedge clk_i);
    chk("s4_stray_accepted", {63'h0, rx_ready_o}, 64'h1);
    if (stray_o) pulses++;
    @(posedge clk_i); #1;
    idle_rx();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (stray_o) pulses++;
      if (out_valid_o) chk("s4_no_beat_from_stray", 64'h1, 64'h0);
      @(posedge clk_i); #1;
    end
    chk("s4_stray_pulses", 64'(pulses), 64'h1);

    // Single word into upper lane
    sb.push_back(mk(32'h7777_0000, 4'hC, 1'b1, 1'b0));
    send_cmd(16'd0, 1'b1);
    send_word(16'h7777, st);
    idle_rx();
    drain_sb("s5_drain");

    // Reset mid-burst
    send_cmd(16'd3, 1'b0);
    send_word(16'h1111, st);
    idle_rx();
    rst_i = 1'b1;
    #1;
    chk("s6_rst_out_valid", {63'h0, out_valid_o}, 64'h0);
    chk("s6_rst_cmd_ready", {63'h0, cmd_ready_o}, 64'h1);
    chk("s6_rst_busy", {63'h0, busy_o}, 64'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    scenario1("s6");

    repeat (3) @(posedge clk_i);
    chk("final_sb_empty", 64'(sb.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
